e203_ifu_litebpu_ras: RTL and testbench

//  IFU-side consumer of the mini-decode info bus: takes per-instruction bjp decode (jal/jalr/bxx,
//  imm, jalr rs1 index, rd index) and produces the static branch prediction plus next-PC adder

---
 rtl/e203_ifu_litebpu_ras.sv | 94 +++++++++
 tb/tb_e203_ifu_litebpu_ras.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/e203_ifu_litebpu_ras.sv
// e203_ifu_litebpu_ras: static branch predictor with return-address stack and JALR rs1 read FSM
module e203_ifu_litebpu_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            dec_i_valid,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic            dec_bxx,
  input  logic            dec_rv32,
  input  logic [XLEN-1:0] dec_bjp_imm,
  input  logic [4:0]      dec_jalr_rs1idx,
  input  logic [4:0]      dec_rdidx,
  input  logic            bpu_fire,
  input  logic            ras_flush,
  input  logic            oitf_empty,
  input  logic            ir_empty,
  input  logic            ir_rs1en,
  input  logic            ir_valid_clr,
  input  logic            jalr_rs1idx_cam_irrdidx,
  input  logic [XLEN-1:0] rf2bpu_x1,
  input  logic [XLEN-1:0] rf2bpu_rs1,
  output logic            prdt_taken,
  output logic [XLEN-1:0] prdt_pc_add_op1,
  output logic [XLEN-1:0] prdt_pc_add_op2,
  output logic            bpu_wait,
  output logic            bpu2rf_rs1_ena,
  output logic            ras_hit
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);
  typedef enum logic {IDLE, RDRF} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic rs1_x0, rs1_x1, rs1_xn, ras_ret, ras_call, x1_dep, xn_dep, ras_upd, nonempty;
  logic [XLEN-1:0] link;
  always_comb begin
    rs1_x0 = dec_jalr_rs1idx == 5'd0;
    rs1_x1 = dec_jalr_rs1idx == 5'd1;
    rs1_xn = ~rs1_x0 & ~rs1_x1;
    nonempty = cnt_q != '0;
    ras_ret = dec_jalr & rs1_x1 & (dec_rdidx == 5'd0);
    ras_call = (dec_jal | dec_jalr) & (dec_rdidx == 5'd1);
    ras_hit = dec_i_valid & ras_ret & nonempty;
    x1_dep = ~oitf_empty | (~ir_empty & jalr_rs1idx_cam_irrdidx);
    xn_dep = x1_dep | (ir_rs1en & ~ir_valid_clr);
    // During reset no regfile read or stall is requested, even mid-read
    bpu2rf_rs1_ena = ~rst & dec_i_valid & dec_jalr & rs1_xn & ~xn_dep & (state_q == IDLE);
    bpu_wait = ~rst & dec_i_valid & dec_jalr &
               (rs1_x1 ? (~ras_hit & x1_dep) : (rs1_xn & (state_q == IDLE)));
    prdt_taken = dec_i_valid & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]));
    prdt_pc_add_op2 = dec_i_valid ? dec_bjp_imm : '0;
    prdt_pc_add_op1 = ~dec_i_valid ? '0 : ~dec_jalr ? pc : rs1_x0 ? '0 :
                      ras_hit ? ras_q[ptr_q] : rs1_x1 ? rf2bpu_x1 : rf2bpu_rs1;
    link = pc + (dec_rv32 ? XLEN'(4) : XLEN'(2));
    ras_upd = dec_i_valid & bpu_fire & ~bpu_wait;
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (ras_upd & ras_call & ras_ret & nonempty) ras_d[ptr_q] = link;
    else if (ras_upd & ras_call) begin
      ptr_d = ptr_q + 1'b1;
      ras_d[ptr_d] = link;
      cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
    end else if (ras_upd & ras_ret & nonempty) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    if (ras_flush) begin
      ptr_d = '0;
      cnt_d = '0;
    end
    state_d = (~ras_flush & (state_q == IDLE) & bpu2rf_rs1_ena) ? RDRF : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      ras_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end
endmodule

// File: tb/tb_e203_ifu_litebpu_ras.sv
// tb_e203_ifu_litebpu_ras: directed scenario tests for the lite BPU with RAS
module tb_e203_ifu_litebpu_ras;
  logic clk = 0, rst;
  logic [31:0] pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1, op1, op2;
  logic dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_rv32, bpu_fire, ras_flush;
  logic oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, cam;
  logic [4:0] rs1idx, rdidx;
  logic taken, bwait, ena, hit;
  int cmps = 0, errs = 0;
  always #5 clk = ~clk;
  e203_ifu_litebpu_ras #(.RAS_DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
    .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_rv32(dec_rv32), .dec_bjp_imm(dec_bjp_imm),
    .dec_jalr_rs1idx(rs1idx), .dec_rdidx(rdidx), .bpu_fire(bpu_fire), .ras_flush(ras_flush),
    .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_rs1en(ir_rs1en), .ir_valid_clr(ir_valid_clr),
    .jalr_rs1idx_cam_irrdidx(cam), .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .prdt_taken(taken), .prdt_pc_add_op1(op1), .prdt_pc_add_op2(op2), .bpu_wait(bwait),
    .bpu2rf_rs1_ena(ena), .ras_hit(hit));
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic clr();
    dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0; dec_rv32 = 1; dec_bjp_imm = 0;
    rs1idx = 0; rdidx = 0; pc = 0; bpu_fire = 0; ras_flush = 0;
    oitf_empty = 1; ir_empty = 1; ir_rs1en = 0; ir_valid_clr = 0; cam = 0;
  endtask
  task automatic dec(input logic [2:0] cls, input logic [31:0] p, input logic [31:0] im,
                     input logic [4:0] rs1, input logic [4:0] rd, input logic v32, input logic f);
    dec_i_valid = 1; {dec_jal, dec_jalr, dec_bxx} = cls; pc = p; dec_bjp_imm = im;
    rs1idx = rs1; rdidx = rd; dec_rv32 = v32; bpu_fire = f; #1;
  endtask
  task automatic test_reset();
    cmps++; if (taken !== 0) begin errs++; $display("FAIL reset_taken got %h want 0", taken); end
    cmps++; if (op1 !== 0 || op2 !== 0) begin errs++; $display("FAIL reset_ops got %h/%h want 0/0", op1, op2); end
    cmps++; if ({bwait, ena, hit} !== 3'b000) begin errs++; $display("FAIL reset_ctl got %b want 000", {bwait, ena, hit}); end
  endtask
  task automatic test_jal();
    dec(3'b100, 32'h8000_0000, 32'h100, 5'd0, 5'd0, 1, 1);
    cmps++; if (taken !== 1) begin errs++; $display("FAIL jal_taken got %h want 1", taken); end
    cmps++; if (op1 !== 32'h8000_0000) begin errs++; $display("FAIL jal_op1 got %h want 80000000", op1); end
    cmps++; if (op2 !== 32'h100) begin errs++; $display("FAIL jal_op2 got %h want 100", op2); end
    cmps++; if (bwait !== 0) begin errs++; $display("FAIL jal_wait got %h want 0", bwait); end
    step();
    dec(3'b010, 32'h0, 32'h0, 5'd1, 5'd0, 1, 0);
    cmps++; if (hit !== 0 || op1 !== rf2bpu_x1) begin errs++; $display("FAIL jal_nopush got hit=%h op1=%h want 0/%h", hit, op1, rf2bpu_x1); end
    clr();
  endtask
  task automatic test_bxx();
    dec(3'b001, 32'h400, 32'hFFFF_FFF8, 5'd0, 5'd0, 1, 0);
    cmps++; if (taken !== 1 || op1 !== 32'h400) begin errs++; $display("FAIL bxx_back got %h/%h want 1/400", taken, op1); end
    dec(3'b001, 32'h400, 32'h8, 5'd0, 5'd0, 1, 0);
    cmps++; if (taken !== 0 || op1 !== 32'h400 || op2 !== 32'h8) begin errs++; $display("FAIL bxx_fwd got %h/%h/%h want 0/400/8", taken, op1, op2); end
    clr();
  endtask
  task automatic test_call_ret();
    dec(3'b100, 32'h1000, 32'h20, 5'd0, 5'd1, 1, 1); step();
    oitf_empty = 0;
    dec(3'b010, 32'h2000, 32'h0, 5'd1, 5'd0, 1, 1);
    cmps++; if (hit !== 1 || op1 !== 32'h1004 || bwait !== 0) begin errs++; $display("FAIL ret_hit got %h/%h/%h want 1/1004/0", hit, op1, bwait); end
    step(); #1;
    cmps++; if (hit !== 0 || bwait !== 1 || op1 !== rf2bpu_x1) begin errs++; $display("FAIL ret_empty got %h/%h/%h want 0/1/%h", hit, bwait, op1, rf2bpu_x1); end
    oitf_empty = 1;
    dec(3'b100, 32'h2000, 32'h0, 5'd0, 5'd1, 0, 1); step();
    dec(3'b010, 32'h0, 32'h0, 5'd1, 5'd0, 1, 1);
    cmps++; if (hit !== 1 || op1 !== 32'h2002) begin errs++; $display("FAIL ret_rvc got %h/%h want 1/2002", hit, op1); end
    step();
    dec(3'b100, 32'hFFFF_FFFC, 32'h0, 5'd0, 5'd1, 1, 1); step();
    dec(3'b010, 32'h0, 32'h0, 5'd1, 5'd0, 1, 1);
    cmps++; if (hit !== 1 || op1 !== 32'h0) begin errs++; $display("FAIL ret_wrap got %h/%h want 1/0", hit, op1); end
    step(); clr();
  endtask
  task automatic test_jalr_xn();
    dec(3'b010, 32'h0, 32'h10, 5'd0, 5'd0, 1, 0);
    cmps++; if (op1 !== 0 || bwait !== 0 || ena !== 0) begin errs++; $display("FAIL jalr_x0 got %h/%h/%h want 0/0/0", op1, bwait, ena); end
    oitf_empty = 0;
    dec(3'b010, 32'h0, 32'h10, 5'd5, 5'd0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cmps++; if (bwait !== 1 || ena !== 0) begin errs++; $display("FAIL xn_dep%0d got %h/%h want 1/0", i, bwait, ena); end
      step();
    end
    oitf_empty = 1; #1;
    cmps++; if (bwait !== 1 || ena !== 1) begin errs++; $display("FAIL xn_issue got %h/%h want 1/1", bwait, ena); end
    step();
    cmps++; if (bwait !== 0 || ena !== 0 || op1 !== rf2bpu_rs1 || taken !== 1) begin errs++; $display("FAIL xn_rdrf got %h/%h/%h/%h want 0/0/%h/1", bwait, ena, op1, taken, rf2bpu_rs1); end
    step();
    cmps++; if (ena !== 1 || bwait !== 1) begin errs++; $display("FAIL xn_back_idle got %h/%h want 1/1", ena, bwait); end
    ir_rs1en = 1; #1;
    cmps++; if (ena !== 0 || bwait !== 1) begin errs++; $display("FAIL xn_irdep got %h/%h want 0/1", ena, bwait); end
    ir_valid_clr = 1; #1;
    cmps++; if (ena !== 1) begin errs++; $display("FAIL xn_irclr got %h want 1", ena); end
    clr(); step();
  endtask
  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      dec(3'b100, 32'h100 * k, 32'h0, 5'd0, 5'd1, 1, 1); step();
    end
    for (int k = 5; k >= 1; k--) begin
      dec(3'b010, 32'h0, 32'h0, 5'd1, 5'd0, 1, 1);
      if (k >= 2) begin
        cmps++; if (hit !== 1 || op1 !== 32'h100 * k + 4) begin errs++; $display("FAIL ovf_ret%0d got %h/%h want 1/%h", k, hit, op1, 32'h100 * k + 4); end
      end else begin
        cmps++; if (hit !== 0 || op1 !== rf2bpu_x1) begin errs++; $display("FAIL ovf_fallback got %h/%h want 0/%h", hit, op1, rf2bpu_x1); end
      end
      step();
    end
    clr();
  endtask
  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      dec(3'b100, 32'h40 * k, 32'h0, 5'd0, 5'd1, 1, 1); step();
    end
    clr(); ras_flush = 1; step(); ras_flush = 0;
    dec(3'b010, 32'h0, 32'h0, 5'd1, 5'd0, 1, 0);
    cmps++; if (hit !== 0 || op1 !== rf2bpu_x1) begin errs++; $display("FAIL flush_ret got %h/%h want 0/%h", hit, op1, rf2bpu_x1); end
    clr(); step();
  endtask
  task automatic test_rst_rdrf();
    dec(3'b010, 32'h0, 32'h0, 5'd7, 5'd0, 1, 1); step();
    cmps++; if (bwait !== 0 || ena !== 0) begin errs++; $display("FAIL rdrf_enter got %h/%h want 0/0", bwait, ena); end
    #2 rst = 1; #1;
    cmps++; if (bwait !== 0 || ena !== 0) begin errs++; $display("FAIL rst_rdrf got %h/%h want 0/0", bwait, ena); end
    step(); rst = 0; #1;
    cmps++; if (bwait !== 1 || ena !== 1) begin errs++; $display("FAIL rst_idle got %h/%h want 1/1", bwait, ena); end
    clr();
  endtask
  initial begin
    rf2bpu_x1 = 32'hAAAA_0000; rf2bpu_rs1 = 32'h5555_1234;
    clr(); rst = 1;
    step(); step();
    test_reset();
    rst = 0; step();
    test_jal();
    test_bxx();
    test_call_ret();
    test_jalr_xn();
    test_overflow();
    test_flush();
    test_rst_rdrf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
